// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences byte/halfword/word loads and stores over a byte-wide req/ack bus
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [1:0]  i_mem_data_size,
    input  logic        i_mem_data_sign,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [7:0]  o_bus_wdata,
    input  logic [7:0]  i_bus_rdata,
    input  logic        i_bus_ack
);
    typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;
    state_t r_state, w_state;
    logic [1:0]  r_k, w_k, r_size, w_size, w_last, w_k1;
    logic [7:0]  r_to, w_to, w_to_inc;
    logic        r_sign, w_sign, r_we, w_we, w_bad, w_err;
    logic [31:0] r_addr, w_addr, r_wdata, w_wdata, r_buf, w_buf, w_ext;
    logic [31:0] w_rdata, w_bus_addr;
    logic        w_bus_req, w_bus_we;
    logic [7:0]  w_bus_wdata;
    assign w_bad = (i_mem_read & i_mem_write) | (i_mem_data_size == 2'd0)
                 | (i_mem_data_size == 2'd2 & i_addr[0])
                 | (i_mem_data_size == 2'd3 & |i_addr[1:0]);
    // index of the final byte: size 01 -> 0, 10 -> 1, 11 -> 3
    assign w_last = {&r_size, r_size[1]};
    assign w_k1 = r_k + 2'd1;
    assign w_to_inc = r_to + 8'd1;
    assign w_ext = r_size == 2'd1 ? {{24{r_sign & w_buf[7]}}, w_buf[7:0]} :
                   r_size == 2'd2 ? {{16{r_sign & w_buf[15]}}, w_buf[15:0]} : w_buf;
    always_comb begin
        w_buf = r_buf;
        w_buf[{r_k, 3'b000} +: 8] = i_bus_rdata;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_to        <= '0;
            r_size      <= '0;
            r_sign      <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_buf       <= '0;
            o_rdata     <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
        end else begin
            r_state     <= w_state;
            r_k         <= w_k;
            r_to        <= w_to;
            r_size      <= w_size;
            r_sign      <= w_sign;
            r_we        <= w_we;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_buf       <= (r_state == XFER && i_bus_ack) ? w_buf : r_buf;
            o_rdata     <= w_rdata;
            o_busy      <= w_state != IDLE;
            o_done      <= w_state == FIN;
            o_err       <= w_err;
            o_bus_req   <= w_bus_req;
            o_bus_we    <= w_bus_we;
            o_bus_addr  <= w_bus_addr;
            o_bus_wdata <= w_bus_wdata;
        end
    end
    always_comb begin
        w_state     = r_state;
        w_k         = r_k;
        w_to        = r_to;
        w_size      = r_size;
        w_sign      = r_sign;
        w_we        = r_we;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_err       = 1'b0;
        w_rdata     = o_rdata;
        w_bus_req   = o_bus_req;
        w_bus_we    = o_bus_we;
        w_bus_addr  = o_bus_addr;
        w_bus_wdata = o_bus_wdata;
        case (r_state)
            IDLE: if (i_start) begin
                if (w_bad) begin
                    w_state = FIN;
                    w_err   = 1'b1;
                end else if (!i_mem_read && !i_mem_write) begin
                    w_state = FIN;
                end else begin
                    w_state     = XFER;
                    w_k         = '0;
                    w_to        = '0;
                    w_size      = i_mem_data_size;
                    w_sign      = i_mem_data_sign;
                    w_we        = i_mem_write;
                    w_addr      = i_addr;
                    w_wdata     = i_wdata;
                    w_bus_req   = 1'b1;
                    w_bus_we    = i_mem_write;
                    w_bus_addr  = i_addr;
                    w_bus_wdata = i_wdata[7:0];
                end
            end
            XFER: if (i_bus_ack) begin
                if (r_k == w_last) begin
                    w_state   = FIN;
                    w_bus_req = 1'b0;
                    w_rdata   = r_we ? o_rdata : w_ext;
                end else begin
                    w_k         = w_k1;
                    w_to        = '0;
                    w_bus_addr  = r_addr + {30'd0, w_k1};
                    w_bus_wdata = r_wdata[{w_k1, 3'b000} +: 8];
                end
            end else begin
                w_to = w_to_inc;
                if (w_to_inc == 8'(TIMEOUT_CYCLES)) begin
                    w_state   = FIN;
                    w_bus_req = 1'b0;
                    w_err     = 1'b1;
                end
            end
            FIN: w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory sequencer that executes one load/store per request, driven by the decoded memory controls: mem_read, mem_write, mem_data_size, mem_data_sign.
- Sits between the execute stage and a byte-wide memory bus.
- Splits byte/halfword/word accesses into byte transfers with a req/ack handshake, then reassembles and extends load data.
- Holds the pipeline via busy while a transfer is in progress.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles to wait for bus_ack on one byte before aborting with err; range 1..255.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  request strobe; sampled only in IDLE
- mem_read  input  1  load request
- mem_write  input  1  store request
- mem_data_size  input  2  01 byte, 10 halfword, 11 word; 00 illegal
- mem_data_sign  input  1  1 = sign-extend load, 0 = zero-extend; ignored for stores and words
- addr  input  32  byte address
- wdata  input  32  store data; low bytes used for byte/halfword
- rdata  output  32  extended load result
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse, coincident with done, on a failed request
- bus_req  output  1  byte transfer request
- bus_we  output  1  1 = write byte
- bus_addr  output  32  byte address of current transfer
- bus_wdata  output  8  byte to write
- bus_rdata  input  8  byte read
- bus_ack  input  1  transfer complete, sampled at rising edge while bus_req = 1

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - state = IDLE, byte counter = 0, timeout counter = 0.
  - rdata = 0; busy, done, err, bus_req, bus_we = 0; bus_addr = 0; bus_wdata = 0.
  - Reset mid-transfer aborts with no done/err. bus_req is low in the cycle after the reset edge.
- States: IDLE, XFER, FIN. All outputs are registered.
- IDLE, start = 1 at an edge, request is checked in this order:
  - mem_read and mem_write both 1, or mem_data_size = 00, or misaligned (halfword with addr[0] = 1, word with addr[1:0] != 0):
    - go to FIN with err pending; no bus activity.
  - Neither mem_read nor mem_write: go to FIN, no error, rdata unchanged.
  - Otherwise:
    - latch controls, addr, wdata.
    - N = 1/2/4 bytes.
    - go to XFER with bus_req = 1, bus_addr = addr, bus_we = mem_write, bus_wdata = wdata[7:0].
- start while busy: ignored, not queued.
- XFER:
  - Edge with bus_ack = 1 completes byte k (k = 0..N-1).
    - Load: capture bus_rdata into result byte k (little-endian: byte at addr+k maps to bits 8k+7:8k).
    - k < N-1: bus_req stays 1; bus_addr = addr+k+1; bus_wdata = wdata[8(k+1)+7:8(k+1)]; timeout counter cleared. Back-to-back transfers have no idle cycle.
    - k = N-1: bus_req = 0, go to FIN.
  - Edge with bus_ack = 0: timeout counter increments.
    - Reaching TIMEOUT_CYCLES: bus_req = 0, go to FIN with err pending; rdata not updated.
  - bus_ack while bus_req = 0 is ignored.
- FIN:
  - done = 1 for exactly one cycle; err = 1 in the same cycle if pending.
  - Successful load: rdata is updated at the FIN entry edge.
    - Byte: bits 31:8 = mem_data_sign ? bit7 : 0.
    - Halfword: bits 31:16 = mem_data_sign ? bit15 : 0.
    - Word: unchanged.
  - Next edge: IDLE, busy = 0.
  - rdata holds its value until the next successful load.
- Latency:
  - With bus_ack tied 1, an N-byte access accepted at edge 0 completes bytes at edges 1..N.
  - done is high after edge N, i.e. N+1 cycles of busy.
  - Error/no-op requests: done is high after edge 0 (1 cycle of busy).
- Address arithmetic is 32-bit. Wrap-around from 0xFFFFFFFF is impossible because aligned accesses never cross.

Test Plan:
- Reset, then bus_ack = 1, memory bytes [0x100..0x103] = 80 FF 34 12; LW addr 0x100 -> bus_addr 0x100,0x101,0x102,0x103 on consecutive cycles; done after 5 busy cycles; rdata = 0x1234FF80.
- LB signed addr 0x100 -> rdata = 0xFFFFFF80; LBU (mem_data_sign = 0) -> 0x00000080; LH signed addr 0x102 -> 0x00001234; LH signed addr 0x100 -> 0xFFFFFF80.
- SH addr 0x200, wdata 0xAABBCCDD -> two write transfers: (0x200, DD), (0x201, CC); bus_we = 1; rdata unchanged; no err.
- LW addr 0x102 and LH addr 0x101 -> done and err together 1 cycle after start; bus_req never asserted.
- bus_ack = 0 with TIMEOUT_CYCLES = 4 on LB -> bus_req high 4 cycles, then done + err, bus_req low.
- LW with ack delayed 3 cycles per byte, rst_n = 0 after byte 1 -> next cycle bus_req = 0, busy = 0, done = 0, rdata = 0; a following start is accepted normally.
